// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Round-robin arbiter for the single register-file write port. Several
// write-back sources (ALU, load unit, mul/div, ...) offer an address/data
// pair with a valid/ready handshake. At most one source is accepted per
// cycle. The accepted pair is registered and presented to the register
// storage as a one-cycle write strobe. Writes to register 0 still complete
// the handshake, but the strobe stays low.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   hold       1 = pipeline owns the port: no grants, pointer frozen
//   req_valid  per-source request
//   req_addr   per-source address, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   per-source data,    source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-source accept (combinational, one-hot or zero)
//   wr_en      registered write strobe
//   wr_addr    registered write address
//   wr_data    registered write data
//   grant_id   registered index of the last accepted source
//   wait_cnt   per-source saturating count of consecutive valid-but-not-
//              accepted cycles, source i at [i*CNT_WIDTH +: CNT_WIDTH]

module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [2:0]                      grant_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    wait_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Advance an index by one, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

  // State
  logic [PTR_W-1:0]      ptr_q,     ptr_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [2:0]            gid_q,     gid_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REQ];

  // Arbitration results
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NUM_REQ-1:0]    ready_d;

  // Scan from the priority pointer, wrapping, and take the first valid
  // source. The reset term keeps req_ready low while reset is asserted,
  // since the handshake is combinational and would otherwise follow valid.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    if (reset && !hold) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
        cand = inc_wrap(cand);
      end
    end
  end

  always_comb begin
    ready_d  = '0;
    win_addr = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_data = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    if (win_found) begin
      ready_d[win_idx] = 1'b1;
    end
  end

  assign req_ready = ready_d;

  // Output register and pointer next-state. Without a transfer everything
  // except the strobe keeps its previous value.
  always_comb begin
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    if (win_found) begin
      ptr_d     = inc_wrap(win_idx);
      gid_d     = 3'(win_idx);
      wr_addr_d = win_addr;
      wr_data_d = win_data;
      // Register 0 is hardwired to zero: accept the source but drop the write.
      wr_en_d   = (win_addr != '0);
    end
  end

  // Wait counters: count while requesting and not accepted, saturate,
  // clear on acceptance or when the request goes away.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = '0;
      if (req_valid[i] && !ready_d[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      gid_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = gid_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait_pack
    assign wait_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  // Structural invariants of the arbiter.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_ready));

  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!reset)
    ((req_ready & ~req_valid) == '0));

  a_ptr_in_range : assert property (@(posedge clk) disable iff (!reset)
    (ptr_q <= LAST_IDX));

  a_hold_blocks : assert property (@(posedge clk) disable iff (!reset)
    (hold |-> (req_ready == '0)));

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter that shares the single register-file write port of the MIPS datapath among NUM_REQ write-back sources (e.g. ALU, load unit, multiply/divide unit). Each source offers an address/data pair with a valid/ready handshake; the arbiter grants at most one source per cycle and issues a registered write strobe, address and data to the register storage. It also suppresses writes to register 0 and freezes arbitration while the pipeline holds the port.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register address
- NUM_REQ, 3, number of requesting sources (2..8)
- CNT_WIDTH, 8, width of per-requester wait counters

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- hold  input  1  1 = no grants this cycle; pointer frozen
- req_valid  input  NUM_REQ  bit i: source i offers a write
- req_addr  input  NUM_REQ*ADDR_WIDTH  source i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  source i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  bit i: source i accepted this cycle (combinational, one-hot or zero)
- wr_en  output  1  registered write strobe to register storage
- wr_addr  output  ADDR_WIDTH  registered write address
- wr_data  output  DATA_WIDTH  registered write data
- grant_id  output  3  registered index of last accepted source
- wait_cnt  output  NUM_REQ*CNT_WIDTH  per-source saturating count of consecutive cycles valid but not accepted

## Operation
- State: priority pointer ptr (0..NUM_REQ-1), output registers, wait counters.
- Arbitration each cycle: if hold=0, scan i = ptr, ptr+1, …, wrapping modulo NUM_REQ; first i with req_valid[i]=1 is the winner. req_ready[winner]=1, all other bits 0. If hold=1 or no valid, req_ready=0.
- Transfer occurs when req_valid[i] & req_ready[i]. Sources hold valid, addr, data stable until accepted; dropping valid before acceptance is legal and forfeits the slot without side effects.
- On transfer from source k: ptr <= (k+1) mod NUM_REQ; grant_id <= k; wr_addr <= req_addr[k]; wr_data <= req_data[k]; wr_en <= 1 unless req_addr[k] == 0, in which case wr_en <= 0 (handshake still completes, write discarded).
- No transfer: wr_en <= 0; ptr, grant_id, wr_addr, wr_data keep previous values.
- Wait counters: for each i, if req_valid[i] & ~req_ready[i], wait_cnt[i] increments, saturating at all-ones; otherwise cleared to 0 (including on acceptance and when valid is low).
- Fairness: with all sources continuously valid and hold=0, each source is granted exactly once per NUM_REQ cycles; max wait = NUM_REQ-1 cycles.

## Timing
- Reset (reset=0, asynchronous, takes effect immediately): wr_en=0, wr_addr=0, wr_data=0, grant_id=0, ptr=0, all wait_cnt=0. req_ready is 0 while reset=0.
- Release of reset is sampled synchronously; first grant possible in the first clk edge with reset=1.
- Latency: transfer at edge T -> wr_en/wr_addr/wr_data valid during cycle after T, one cycle wide.
- Throughput: one write per cycle, back-to-back from same or different sources.
- hold rising: no transfer that cycle; wr_en falls after the next edge. hold has priority over any valid.
- Reset asserted mid-stream: any in-flight write strobe is cleared immediately; no write is replayed after release.
- Single source continuously valid: granted every cycle (pointer wraps past idle sources).

## Test plan
- Reset: drive reset=0 with all valids high -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0, ptr=0, wait_cnt=0.
- Round-robin: NUM_REQ=3, all valid continuously, addrs 1/2/3, data 0xA/0xB/0xC -> wr_en every cycle, wr_addr sequence 1,2,3,1,2,3; grant_id 0,1,2,0.
- Register-0 suppression: source 1 alone writes addr 0, data 0xDEADBEEF -> req_ready[1]=1 for one cycle, wr_en stays 0, grant_id=1, ptr=2.
- Hold: all valid, hold=1 for 4 cycles -> req_ready=0, wr_en=0, ptr unchanged, wait_cnt each reaches 4; on release the source at ptr wins first and its counter clears.
- Saturation: CNT_WIDTH=2, hold=1 for 6 cycles with source 0 valid -> wait_cnt[0] stops at 3.
- Async reset mid-stream: reset=0 between edges while wr_en=1 -> wr_en drops immediately; after release, source 0 has priority again.
